// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Bundles the command handshake and the open-drain PS/2 pad signals of the
//   PS/2 host transmitter.
//
//   Command side : tx_data, tx_start (to the transmitter)
//                  busy, done, err, rx_inhibit (from the transmitter)
//   Pad side     : ps2_clk_in, ps2_data_in (raw pad levels, to the transmitter)
//                  ps2_clk_oe, ps2_data_oe (1 = pull line low, from the transmitter)
//
//   Modports:
//     master - CPU/bus side plus pad model (drives requests and pad levels)
//     slave  - the transmitter itself
//
//   Handshake: tx_start is a single-cycle request that is accepted only in a
//   cycle where busy is 0; a request seen while busy is 1 is dropped. Every
//   accepted request ends with exactly one single-cycle done or err pulse,
//   unless reset aborts it.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       err;
    logic       rx_inhibit;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport master (
        output tx_data,
        output tx_start,
        output ps2_clk_in,
        output ps2_data_in,
        input  busy,
        input  done,
        input  err,
        input  rx_inhibit,
        input  ps2_clk_oe,
        input  ps2_data_oe
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        input  ps2_clk_in,
        input  ps2_data_in,
        output busy,
        output done,
        output err,
        output rx_inhibit,
        output ps2_clk_oe,
        output ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the keyboard:
//   holds the clock low to inhibit the device, issues request-to-send (data
//   low, clock released), then shifts out 8 data bits LSB first, odd parity
//   and the stop bit on device-generated falling clock edges, and checks the
//   device acknowledge on the 11th edge. rx_inhibit gates the scancode
//   receiver for the whole transaction.
//
//   Ports:
//     clk     - system clock (25 MHz)
//     nreset  - asynchronous active-low reset
//     bus     - ps2_host_tx_if.slave: command handshake and PS/2 pad signals
//     state_o - current FSM state (debug)
//
//   Parameters:
//     INHIBIT_CYCLES - cycles the clock line is held low before the request (>= 2)
//     TIMEOUT_CYCLES - max cycles between consecutive awaited bus events
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic          clk,
    input  logic          nreset,
    ps2_host_tx_if.slave  bus,
    output logic [2:0]    state_o
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQUEST = 3'd2,
        S_SHIFT   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    // One counter serves both as the inhibit timer and as the timeout timer;
    // the two phases never overlap.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    n_q, n_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          drv_q, drv_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Pad synchronizers; reset to the idle (released, high) bus level so that
    // leaving reset never looks like a falling edge.
    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_prev_q;
    logic          clk_s;
    logic          data_s;
    logic          fall;

    logic [3:0]    n_next;
    logic [2:0]    bit_idx;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_s;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk_in};
            data_sync_q <= {data_sync_q[0], bus.ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            drv_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            data_q  <= data_d;
            par_q   <= par_d;
            drv_q   <= drv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        data_d  = data_q;
        par_d   = par_q;
        drv_d   = drv_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        n_next  = n_q + 4'd1;
        bit_idx = 3'(n_next - 4'd1);

        case (state_q)
            S_IDLE: begin
                drv_d = 1'b0;
                if (bus.tx_start) begin
                    data_d  = bus.tx_data;
                    par_d   = ~^bus.tx_data;
                    n_d     = '0;
                    cnt_d   = CW'(INHIBIT_CYCLES - 1);
                    state_d = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(TIMEOUT_CYCLES);
                    state_d = S_REQUEST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            // REQUEST and SHIFT share the edge handling: the edge that ends
            // the request is already data edge 1.
            S_REQUEST, S_SHIFT: begin
                if (fall) begin
                    n_d     = n_next;
                    cnt_d   = CW'(TIMEOUT_CYCLES);
                    state_d = S_SHIFT;
                    case (n_next)
                        4'd1, 4'd2, 4'd3, 4'd4,
                        4'd5, 4'd6, 4'd7, 4'd8: drv_d = ~data_q[bit_idx];
                        4'd9:                   drv_d = ~par_q;
                        4'd11: begin
                            drv_d = 1'b0;
                            if (!data_s) begin
                                state_d = S_RELEASE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                        default:                drv_d = 1'b0;
                    endcase
                end else if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    drv_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_RELEASE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state so the async reset
    // releases both lines immediately.
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.rx_inhibit  = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.ps2_clk_oe  = (state_q == S_INHIBIT);
    // Data goes low on the last inhibit cycle: that is the start bit.
    assign bus.ps2_data_oe = ((state_q == S_INHIBIT) && (cnt_q == '0)) ||
                             (state_q == S_REQUEST) ||
                             ((state_q == S_SHIFT) && drv_q);
    assign state_o         = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    localparam int INH = 8;
    localparam int TO  = 200;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [2:0] state_dbg;
    logic       dev_clk = 1'b1;
    logic       dev_data_low = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave),
        .state_o(state_dbg)
    );

    // Open-drain wired-AND of host and device on both lines.
    assign bus.ps2_clk_in  = ~bus.ps2_clk_oe & dev_clk;
    assign bus.ps2_data_in = ~bus.ps2_data_oe & ~dev_data_low;

    always @(negedge clk) begin
        if (bus.done) done_cnt = done_cnt + 1;
        if (bus.err)  err_cnt  = err_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        @(posedge clk);
        #1;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // Pulse tx_start for one cycle; returns at the negedge of the cycle after
    // the accepting edge.
    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    // Device model: waits for request-to-send, then generates npulses clock
    // pulses of 40 cycles, sampling data just before each rising edge.
    // frame[0] = start, [8:1] = data, [9] = parity, [10] = stop.
    task automatic dev_run(input int npulses, input bit ack, output logic [10:0] frame);
        bit ok;
        ok    = 1'b0;
        frame = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.ps2_clk_in && !bus.ps2_data_in) ok = 1'b1;
        end
        check_eq("request_seen", 32'(ok), 32'd1);
        if (ok) begin
            repeat (10) @(negedge clk);
            frame[0] = bus.ps2_data_in;
            for (int i = 0; i < npulses; i++) begin
                dev_clk = 1'b0;
                repeat (20) @(negedge clk);
                if (i < 10) frame[i+1] = bus.ps2_data_in;
                dev_clk = 1'b1;
                if (i == 9 && ack) dev_data_low = 1'b1;
                if (i == 10) dev_data_low = 1'b0;
                repeat (20) @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [10:0] frame;
        int          clk_hi;
        int          first_d;
        int          c;

        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset_outs",
                 {26'd0, bus.busy, bus.done, bus.err, bus.rx_inhibit, bus.ps2_clk_oe, bus.ps2_data_oe},
                 32'd0);
        check_eq("reset_state", 32'(state_dbg), 32'd0);
        nreset = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED with ack: parity 1
        clear_counts();
        exp_q.push_back(11'b1_1_11101101_0);
        start_tx(8'hED);
        check_eq("ed_busy", {31'd0, bus.busy}, 32'd1);
        check_eq("ed_rx_inhibit", {31'd0, bus.rx_inhibit}, 32'd1);
        dev_run(11, 1'b1, frame);
        check_eq("ed_frame", 32'(frame), 32'(exp_q.pop_front()));
        repeat (5) @(negedge clk);
        check_eq("ed_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("ed_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("ed_busy_after", {31'd0, bus.busy}, 32'd0);

        // 0xF4: parity 0, inhibit timing
        clear_counts();
        exp_q.push_back(11'b1_0_11110100_0);
        start_tx(8'hF4);
        clk_hi  = 0;
        first_d = 0;
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.ps2_clk_oe) clk_hi++;
            if (bus.ps2_data_oe && first_d == 0) first_d = i;
            if (i == 9) check_eq("f4_clk_oe_cycle9", {31'd0, bus.ps2_clk_oe}, 32'd0);
        end
        check_eq("f4_clk_oe_len", 32'(clk_hi), 32'd8);
        check_eq("f4_data_oe_rise", 32'(first_d), 32'd8);
        dev_run(11, 1'b1, frame);
        check_eq("f4_frame", 32'(frame), 32'(exp_q.pop_front()));
        repeat (5) @(negedge clk);
        check_eq("f4_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("f4_err_cnt", 32'(err_cnt), 32'd0);

        // No acknowledge
        clear_counts();
        exp_q.push_back(11'b1_1_11101101_0);
        start_tx(8'hED);
        dev_run(11, 1'b0, frame);
        check_eq("nack_frame", 32'(frame), 32'(exp_q.pop_front()));
        repeat (5) @(negedge clk);
        check_eq("nack_err_cnt", 32'(err_cnt), 32'd1);
        check_eq("nack_done_cnt", 32'(done_cnt), 32'd0);
        check_eq("nack_oes", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);

        // Device never clocks: err 200 cycles after REQUEST entry (cycle k+9)
        clear_counts();
        start_tx(8'hF4);
        c = 1;
        while (!bus.err && c < 400) begin
            @(negedge clk);
            c++;
        end
        check_eq("timeout_cycle", 32'(c), 32'(INH + 1 + TO));
        check_eq("timeout_oes", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
        @(negedge clk);
        check_eq("timeout_err_cnt", 32'(err_cnt), 32'd1);
        check_eq("timeout_done_cnt", 32'(done_cnt), 32'd0);
        check_eq("timeout_pads", {30'd0, bus.ps2_clk_in, bus.ps2_data_in}, 32'd3);

        // tx_start while busy is dropped; 0x55 parity 1
        clear_counts();
        exp_q.push_back(11'b1_1_01010101_0);
        start_tx(8'h55);
        repeat (3) @(negedge clk);
        bus.tx_data  = 8'hAA;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        dev_run(11, 1'b1, frame);
        check_eq("busy_drop_frame", 32'(frame), 32'(exp_q.pop_front()));
        repeat (5) @(negedge clk);
        check_eq("busy_drop_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("busy_drop_err_cnt", 32'(err_cnt), 32'd0);

        // Reset after bit 4 (5 edges seen, data bit 4 of 0xED is 0 -> line pulled)
        clear_counts();
        start_tx(8'hED);
        dev_run(5, 1'b0, frame);
        check_eq("abort_partial_frame", {26'd0, frame[5:0]}, 32'h1A);
        check_eq("abort_pre_data_oe", {31'd0, bus.ps2_data_oe}, 32'd1);
        #3;
        nreset = 1'b0;
        #1;
        check_eq("abort_outs",
                 {28'd0, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe, bus.rx_inhibit}, 32'd0);
        check_eq("abort_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        check_eq("abort_no_err", 32'(err_cnt), 32'd0);

        // 0xFF after abort: parity 1
        clear_counts();
        exp_q.push_back(11'b1_1_11111111_0);
        start_tx(8'hFF);
        dev_run(11, 1'b1, frame);
        check_eq("ff_frame", 32'(frame), 32'(exp_q.pop_front()));
        repeat (5) @(negedge clk);
        check_eq("ff_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("ff_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("ff_busy_after", {31'd0, bus.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the CPU to the attached keyboard over the same open-drain PS/2 clock/data pair that the existing PS/2 scancode receiver listens on. It sits in the MemoryUnit I/O space next to the PS/2 receiver. It performs the host request-to-send sequence, shifts out data, odd parity and stop bit on device-generated clocks, and checks the device acknowledge. While it is active it asserts `rx_inhibit` so the receiver ignores bus activity.

## Interface
- INHIBIT_CYCLES, 2500: number of `clk` cycles the PS/2 clock is held low before the request (100 µs at 25 MHz); minimum 2.
- TIMEOUT_CYCLES, 375000: maximum number of `clk` cycles between consecutive awaited bus events (15 ms at 25 MHz).
- clk  in  1  system clock, 25 MHz.
- nreset  in  1  reset, asynchronous, active-low. One clock domain; reset polarity and synchronicity are fixed.
- tx_data  in  8  command byte; sampled when `tx_start` is accepted.
- tx_start  in  1  single-cycle request; ignored unless the block is idle.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse: byte sent and acknowledged by the device.
- err  out  1  one-cycle pulse: missing acknowledge or timeout.
- rx_inhibit  out  1  equals `busy`; gates the PS/2 receiver.
- ps2_clk_in  in  1  raw PS/2 clock pad level (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pad level (asynchronous).
- ps2_clk_oe  out  1  1 = drive the PS/2 clock low; 0 = release the line.
- ps2_data_oe  out  1  1 = drive the PS/2 data low; 0 = release the line.

## Operation
- Input conditioning:
  - `ps2_clk_in` and `ps2_data_in` each pass through a 2-FF synchronizer.
  - A falling edge means synchronized clock was 1 on the previous cycle and is 0 now.
- Parity is odd: `par = ~^tx_data`.
- Accepting a request: `tx_start` in IDLE latches `tx_data` and `par`, clears the edge counter `n` and loads the timeout counter.
- States:
  - IDLE: all outputs low.
  - INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYCLES cycles. `ps2_data_oe` rises on the last INHIBIT cycle (this is the start bit). Then go to REQUEST.
  - REQUEST: `ps2_clk_oe`=0 and `ps2_data_oe`=1. Wait for a falling edge, then go to SHIFT.
  - SHIFT: handles every falling edge, including the first one that ended REQUEST. Increment `n` and act on the new value:
    - n=1..8: `ps2_data_oe` = ~tx_data[n-1], LSB first.
    - n=9: `ps2_data_oe` = ~par.
    - n=10: `ps2_data_oe` = 0 (stop bit; line released).
    - n=11: sample synchronized data. 0 means acknowledge → go to RELEASE. 1 means no acknowledge → `err`, go to IDLE.
  - RELEASE: wait until synchronized clock and data are both 1, then pulse `done` and go to IDLE.
- Timeout:
  - The timeout counter reloads on entry to REQUEST and on every falling edge.
  - It decrements in REQUEST, SHIFT and RELEASE.
  - On reaching 0: release both lines, pulse `err`, go to IDLE.
- Simultaneous events: a falling edge and a timeout expiry in the same cycle → the edge wins.
- `tx_start` while `busy` is dropped; there is no queueing and no error.
- Reset asserted mid-transaction: both open-drain enables drop immediately (asynchronously), the FSM returns to IDLE, and no `done`/`err` is generated.

## Timing
- Reset values: `busy`, `done`, `err`, `rx_inhibit`, `ps2_clk_oe`, `ps2_data_oe` are all 0; FSM is IDLE; counters are 0.
- `tx_start` sampled high at edge k:
  - `busy`=1 and `ps2_clk_oe`=1 from cycle k+1.
  - `ps2_data_oe`=1 from cycle k+INHIBIT_CYCLES.
  - `ps2_clk_oe`=0 from cycle k+INHIBIT_CYCLES+1.
- Device edges are seen by the FSM 2 cycles after the pad edge (synchronizer latency). The data output changes 1 cycle after the FSM sees the edge, i.e. 3 cycles after the pad edge.
- `done`/`err` are high for exactly one cycle, in the first IDLE cycle; `busy` is 0 in that same cycle.
- A new `tx_start` is accepted in that same cycle.
- Exactly one `done` or `err` is produced per accepted transaction, except when it is aborted by reset.

## Test plan
Bench settings: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200. The device model drives a 40-cycle clock period and samples data on rising edges.

- Send 0xED → device receives start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; device acks → one `done` pulse, no `err`, `busy` low afterwards.
- Send 0xF4 → parity bit 0; `ps2_clk_oe` high for exactly 8 cycles starting 1 cycle after `tx_start`; `ps2_data_oe` rises on cycle 8.
- Device withholds the ack (data stays 1 at edge 11) → `err` pulse, both OEs 0, `done` never asserted.
- Device never clocks → `err` exactly 200 cycles after REQUEST entry, lines released.
- Drive `tx_start` again while busy with a different byte → ignored; the original byte completes unchanged.
- Assert `nreset` after bit 4 → OEs drop asynchronously, no pulse; a following send of 0xFF completes with `done`.
